// File: rtl/ysyx_22040088_opnd_stage.sv
// ysyx_22040088_opnd_stage
// Registered ALU operand-preparation stage for the RV64 core.
// Selects both ALU operands, resolves forwarding from NUM_FWD later stages
// (index 0 = youngest, highest priority) and stalls on load-use hazards.
// Optional feature macro: YSYX_22040088_OPND_STAT_EN adds the stall_cnt port
// and its saturating hazard-cycle counter.

module ysyx_22040088_opnd_stage #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         pc,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic [XLEN-1:0]         rdata1,
  input  logic [XLEN-1:0]         rdata2,
  input  logic [XLEN-1:0]         imm,
  input  logic [3:0]              sel_src1,
  input  logic [2:0]              sel_src2,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]      fwd_data_ok,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         alu_src1,
  output logic [XLEN-1:0]         alu_src2
`ifdef YSYX_22040088_OPND_STAT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  logic [XLEN-1:0] reg1;
  logic [XLEN-1:0] reg2;
  logic            ok1;
  logic            ok2;
  logic            use1;
  logic            use2;
  logic            hazard;
  logic            capture;
  logic [XLEN-1:0] reg1_zext;
  logic [XLEN-1:0] reg1_sext;
  logic [XLEN-1:0] src1_next;
  logic [XLEN-1:0] src2_next;

  // Forwarding for operand 1: scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    reg1 = rdata1;
    ok1  = 1'b1;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[5*i +: 5] == rs1) && (rs1 != 5'd0)) begin
        reg1 = fwd_data[XLEN*i +: XLEN];
        ok1  = fwd_data_ok[i];
      end
    end
  end

  // Forwarding for operand 2, same priority rule as operand 1.
  always_comb begin
    reg2 = rdata2;
    ok2  = 1'b1;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[5*i +: 5] == rs2) && (rs2 != 5'd0)) begin
        reg2 = fwd_data[XLEN*i +: XLEN];
        ok2  = fwd_data_ok[i];
      end
    end
  end

  // Word extension is taken from the forwarded value, not the raw read data.
  generate
    if (XLEN > 32) begin : g_wide
      assign reg1_zext = {{(XLEN-32){1'b0}}, reg1[31:0]};
      assign reg1_sext = {{(XLEN-32){reg1[31]}}, reg1[31:0]};
    end else begin : g_narrow
      assign reg1_zext = reg1;
      assign reg1_sext = reg1;
    end
  endgenerate

  // An operand only participates in hazard detection when its register form is selected.
  assign use1 = (sel_src1 == 4'b0001) || (sel_src1 == 4'b0100) || (sel_src1 == 4'b1000);
  assign use2 = (sel_src2 == 3'b001);

  assign hazard   = (use1 && !ok1) || (use2 && !ok2);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready && !flush;

  // Operand 1 mux; anything not exactly one-hot yields zero.
  always_comb begin
    src1_next = '0;
    case (sel_src1)
      4'b0001: src1_next = reg1;
      4'b0010: src1_next = pc;
      4'b0100: src1_next = reg1_zext;
      4'b1000: src1_next = reg1_sext;
      default: src1_next = '0;
    endcase
  end

  // Operand 2 mux; anything not exactly one-hot yields zero.
  always_comb begin
    src2_next = '0;
    case (sel_src2)
      3'b001:  src2_next = reg2;
      3'b010:  src2_next = imm;
      3'b100:  src2_next = {{(XLEN-3){1'b0}}, 3'b100};
      default: src2_next = '0;
    endcase
  end

  // Output register: capture loads a new pair; flush or drain clears valid but keeps data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_src1  <= '0;
      alu_src2  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      alu_src1  <= src1_next;
      alu_src2  <= src2_next;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef YSYX_22040088_OPND_STAT_EN
  // Saturating count of cycles where a request is blocked by a hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040088_opnd_stage.sv
// Testbench for ysyx_22040088_opnd_stage: table of directed single-cycle
// vectors plus hand-written multi-cycle sequences (load-use, backpressure,
// flush, reset). Checks stall_cnt when YSYX_22040088_OPND_STAT_EN is defined.

module tb_ysyx_22040088_opnd_stage;
  localparam int XLEN    = 64;
  localparam int NUM_FWD = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         pc;
  logic [4:0]              rs1;
  logic [4:0]              rs2;
  logic [XLEN-1:0]         rdata1;
  logic [XLEN-1:0]         rdata2;
  logic [XLEN-1:0]         imm;
  logic [3:0]              sel_src1;
  logic [2:0]              sel_src2;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [5*NUM_FWD-1:0]    fwd_rd;
  logic [XLEN*NUM_FWD-1:0] fwd_data;
  logic [NUM_FWD-1:0]      fwd_data_ok;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         alu_src1;
  logic [XLEN-1:0]         alu_src2;
`ifdef YSYX_22040088_OPND_STAT_EN
  logic [31:0]             stall_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_22040088_opnd_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pc         (pc),
    .rs1        (rs1),
    .rs2        (rs2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .imm        (imm),
    .sel_src1   (sel_src1),
    .sel_src2   (sel_src2),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data),
    .fwd_data_ok(fwd_data_ok),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2)
`ifdef YSYX_22040088_OPND_STAT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] rdata1;
    logic [63:0] rdata2;
    logic [63:0] imm;
    logic [3:0]  sel1;
    logic [2:0]  sel2;
    logic [2:0]  fv;
    logic [14:0] frd;
    logic [2:0]  fok;
    logic        ready;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] v_pc, input logic [4:0] v_rs1, input logic [4:0] v_rs2,
                              input logic [63:0] v_rd1, input logic [63:0] v_rd2, input logic [63:0] v_imm,
                              input logic [3:0] v_sel1, input logic [2:0] v_sel2, input logic [2:0] v_fv,
                              input logic [14:0] v_frd, input logic [2:0] v_fok, input logic v_ready,
                              input logic [63:0] v_e1, input logic [63:0] v_e2);
    vec_t v;
    v.pc = v_pc; v.rs1 = v_rs1; v.rs2 = v_rs2; v.rdata1 = v_rd1; v.rdata2 = v_rd2;
    v.imm = v_imm; v.sel1 = v_sel1; v.sel2 = v_sel2; v.fv = v_fv; v.frd = v_frd;
    v.fok = v_fok; v.ready = v_ready; v.e1 = v_e1; v.e2 = v_e2;
    return v;
  endfunction

  task automatic clear_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    pc = '0; rs1 = '0; rs2 = '0; rdata1 = '0; rdata2 = '0; imm = '0;
    sel_src1 = 4'b0010; sel_src2 = 3'b010;
    fwd_valid = '0; fwd_rd = '0; fwd_data_ok = '1;
  endtask

  task automatic apply(input vec_t v);
    pc = v.pc; rs1 = v.rs1; rs2 = v.rs2; rdata1 = v.rdata1; rdata2 = v.rdata2;
    imm = v.imm; sel_src1 = v.sel1; sel_src2 = v.sel2;
    fwd_valid = v.fv; fwd_rd = v.frd; fwd_data_ok = v.fok;
  endtask

  vec_t        vecs[13];
  logic [63:0] prev1;
  logic [63:0] prev2;

  initial begin
    // fwd_data: source 2 = 0x12345678_F0000000, source 1 = 0xB, source 0 = 0xA
    fwd_data = {64'h1234_5678_F000_0000, 64'h0000_0000_0000_000B, 64'h0000_0000_0000_000A};

    vecs[0]  = mk(64'h8000_0000, 0, 0, 0, 0, 0, 4'b0010, 3'b100, 3'b000, 15'h0, 3'b111, 1,
                  64'h0000_0000_8000_0000, 64'd4);
    vecs[1]  = mk(0, 0, 0, 64'hFFFF_FFFF_8000_0001, 0, 64'h123, 4'b0100, 3'b010, 3'b000, 15'h0, 3'b111, 1,
                  64'h0000_0000_8000_0001, 64'h123);
    vecs[2]  = mk(0, 0, 3, 64'hFFFF_FFFF_8000_0001, 64'h55, 0, 4'b1000, 3'b001, 3'b000, 15'h0, 3'b111, 1,
                  64'hFFFF_FFFF_8000_0001, 64'h55);
    vecs[3]  = mk(64'h10, 0, 0, 64'h9, 64'h9, 64'h9, 4'b0011, 3'b011, 3'b000, 15'h0, 3'b111, 1,
                  64'h0, 64'h0);
    vecs[4]  = mk(64'h10, 0, 0, 64'h9, 64'h9, 64'h9, 4'b0000, 3'b000, 3'b000, 15'h0, 3'b111, 1,
                  64'h0, 64'h0);
    vecs[5]  = mk(0, 5, 0, 64'h999, 0, 0, 4'b0001, 3'b100, 3'b011, {5'd0, 5'd5, 5'd5}, 3'b111, 1,
                  64'hA, 64'd4);
    vecs[6]  = mk(0, 0, 0, 64'h1234, 64'h77, 0, 4'b0001, 3'b001, 3'b011, {5'd0, 5'd0, 5'd0}, 3'b111, 1,
                  64'h1234, 64'h77);
    vecs[7]  = mk(0, 5, 0, 64'h999, 0, 64'h3, 4'b0001, 3'b010, 3'b011, {5'd0, 5'd5, 5'd5}, 3'b101, 1,
                  64'hA, 64'h3);
    vecs[8]  = mk(0, 5, 5, 64'h999, 64'h888, 0, 4'b0001, 3'b001, 3'b110, {5'd5, 5'd5, 5'd0}, 3'b111, 1,
                  64'hB, 64'hB);
    vecs[9]  = mk(64'h40, 5, 0, 0, 0, 64'h8, 4'b0010, 3'b010, 3'b011, {5'd0, 5'd0, 5'd5}, 3'b110, 1,
                  64'h40, 64'h8);
    vecs[10] = mk(64'h50, 0, 7, 0, 64'h66, 0, 4'b0010, 3'b001, 3'b010, {5'd0, 5'd7, 5'd0}, 3'b101, 0,
                  64'h0, 64'h0);
    vecs[11] = mk(0, 5, 0, 64'h999, 0, 0, 4'b1000, 3'b100, 3'b100, {5'd5, 5'd0, 5'd0}, 3'b111, 1,
                  64'hFFFF_FFFF_F000_0000, 64'd4);
    vecs[12] = mk(0, 5, 0, 64'h999, 0, 64'h1, 4'b0100, 3'b010, 3'b001, {5'd0, 5'd0, 5'd5}, 3'b110, 0,
                  64'h0, 64'h0);

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset alu_src1", alu_src1, 64'd0);
    check("reset alu_src2", alu_src2, 64'd0);
`ifdef YSYX_22040088_OPND_STAT_EN
    check("reset stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset in_ready", {63'd0, in_ready}, 64'd1);

    prev1 = 64'd0;
    prev2 = 64'd0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      apply(vecs[k]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d in_ready", k), {63'd0, in_ready}, {63'd0, vecs[k].ready});
      @(posedge clk);
      #1;
      if (vecs[k].ready) begin
        prev1 = vecs[k].e1;
        prev2 = vecs[k].e2;
      end
      check($sformatf("vec%0d out_valid", k), {63'd0, out_valid}, {63'd0, vecs[k].ready});
      check($sformatf("vec%0d alu_src1", k), alu_src1, prev1);
      check($sformatf("vec%0d alu_src2", k), alu_src2, prev2);
    end

    // Load-use stall over three cycles, then release
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rs2 = 5'd7; sel_src2 = 3'b001; rdata2 = 64'h66;
    sel_src1 = 4'b0010; pc = 64'h90;
    fwd_valid = 3'b010; fwd_rd = {5'd0, 5'd7, 5'd0}; fwd_data_ok = 3'b101;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("loaduse stall%0d in_ready", k), {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    check("loaduse held out_valid", {63'd0, out_valid}, 64'd0);
    fwd_data_ok = 3'b111;
    #1;
    check("loaduse release in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("loaduse out_valid", {63'd0, out_valid}, 64'd1);
    check("loaduse alu_src2", alu_src2, 64'hB);
    check("loaduse alu_src1", alu_src1, 64'h90);
`ifdef YSYX_22040088_OPND_STAT_EN
    check("loaduse stall_cnt", {32'd0, stall_cnt}, 64'd3);
`endif
    @(negedge clk);
    fwd_data_ok = 3'b101; sel_src2 = 3'b010; imm = 64'h77;
    #1;
    check("imm no stall in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("imm no stall alu_src2", alu_src2, 64'h77);
`ifdef YSYX_22040088_OPND_STAT_EN
    check("imm no stall stall_cnt", {32'd0, stall_cnt}, 64'd3);
`endif

    // Backpressure: drain first, then hold a pair and offer another
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    #1;
    check("drain out_valid", {63'd0, out_valid}, 64'd0);
    check("drain keeps alu_src2", alu_src2, 64'h77);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    sel_src1 = 4'b0010; pc = 64'h1000; sel_src2 = 3'b010; imm = 64'h11;
    @(posedge clk);
    #1;
    check("bp p1 out_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    pc = 64'h2000; imm = 64'h22;
    fwd_valid = 3'b111; fwd_rd = {5'd1, 5'd2, 5'd3};
    #1;
    check("bp blocked in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("bp hold out_valid", {63'd0, out_valid}, 64'd1);
    check("bp hold alu_src1", alu_src1, 64'h1000);
    check("bp hold alu_src2", alu_src2, 64'h11);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("bp swap out_valid", {63'd0, out_valid}, 64'd1);
    check("bp swap alu_src1", alu_src1, 64'h2000);
    check("bp swap alu_src2", alu_src2, 64'h22);

    // Flush together with an accepted request captures nothing
    @(negedge clk);
    pc = 64'h3000; imm = 64'h33; flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush out_valid", {63'd0, out_valid}, 64'd0);
    check("flush alu_src1", alu_src1, 64'h2000);

    // Reset mid-stream drops the held pair
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0; pc = 64'h4000; imm = 64'h44;
    @(posedge clk);
    #1;
    check("pre-rst out_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    rst = 1'b1; pc = 64'h5000;
    @(posedge clk);
    #1;
    check("rst out_valid", {63'd0, out_valid}, 64'd0);
    check("rst alu_src1", alu_src1, 64'd0);
    check("rst alu_src2", alu_src2, 64'd0);
`ifdef YSYX_22040088_OPND_STAT_EN
    check("rst stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
